// File: rtl/bcd_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for the serial BCD adder.
interface bcd_serial_adder_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         invalid;

    // Controlling logic side
    modport master (
        output start, in1, in2, carry_in,
        input  busy, done, sum, carry_out, invalid
    );

    // Adder side
    modport slave (
        input  start, in1, in2, carry_in,
        output busy, done, sum, carry_out, invalid
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder: one decimal digit per clock, LSD first,
// registered decimal carry between digits, start/busy/done handshake.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_serial_adder_if.slave   bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q,    state_nxt;
    logic [W-1:0]  a_q,        a_nxt;
    logic [W-1:0]  b_q,        b_nxt;
    logic          carry_q,    carry_nxt;
    logic [IW-1:0] idx_q,      idx_nxt;
    logic [W-1:0]  shadow_q,   shadow_nxt;
    logic          inv_pend_q, inv_pend_nxt;
    logic          busy_q,     busy_nxt;
    logic          done_q,     done_nxt;
    logic [W-1:0]  sum_q,      sum_nxt;
    logic          cout_q,     cout_nxt;
    logic          inv_q,      inv_nxt;

    logic [3:0]    dig_a;
    logic [3:0]    dig_b;
    logic [4:0]    raw;
    logic [3:0]    dig_sum;
    logic          dig_carry;
    logic          in_bad;

    // Single-digit BCD add/correct stage on the currently indexed digit
    always_comb begin
        dig_a = 4'd0;
        dig_b = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                dig_a = a_q[4*i +: 4];
                dig_b = b_q[4*i +: 4];
            end
        end
        raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry_q};
        if (raw > 5'd9) begin
            dig_sum   = 4'(raw + 5'd6);
            dig_carry = 1'b1;
        end else begin
            dig_sum   = raw[3:0];
            dig_carry = 1'b0;
        end
    end

    // Flags any non-BCD digit on the incoming operands
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.in1[4*i +: 4] > 4'd9 || bus.in2[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_nxt    = state_q;
        a_nxt        = a_q;
        b_nxt        = b_q;
        carry_nxt    = carry_q;
        idx_nxt      = idx_q;
        shadow_nxt   = shadow_q;
        inv_pend_nxt = inv_pend_q;
        sum_nxt      = sum_q;
        cout_nxt     = cout_q;
        inv_nxt      = inv_q;
        // Outputs lag the state by one register stage
        busy_nxt     = (state_q != S_IDLE);
        done_nxt     = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt    = S_ADD;
                    a_nxt        = bus.in1;
                    b_nxt        = bus.in2;
                    carry_nxt    = bus.carry_in;
                    idx_nxt      = '0;
                    shadow_nxt   = '0;
                    inv_pend_nxt = in_bad;
                end
            end
            S_ADD: begin
                carry_nxt = dig_carry;
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (idx_q == IW'(i)) begin
                        shadow_nxt[4*i +: 4] = dig_sum;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                sum_nxt   = shadow_q;
                cout_nxt  = carry_q;
                inv_nxt   = inv_pend_q;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            shadow_q   <= '0;
            inv_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            carry_q    <= carry_nxt;
            idx_q      <= idx_nxt;
            shadow_q   <= shadow_nxt;
            inv_pend_q <= inv_pend_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            sum_q      <= sum_nxt;
            cout_q     <= cout_nxt;
            inv_q      <= inv_nxt;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: driver pushes expected results,
// monitor pops and compares on every done pulse.
module tb_bcd_serial_adder;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         inv;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;
    logic         last_inv  = 1'b0;
    exp_t         mon_e;

    bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: decimal arithmetic for valid BCD, per-digit rule otherwise
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input int at_cyc);
        exp_t   e;
        bit     ok;
        longint va, vb, t, lim;
        int     s, ca;
        ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        e.cyc = at_cyc;
        e.inv = !ok;
        e.sum = '0;
        if (ok) begin
            va = 0; vb = 0; lim = 1;
            for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
                va  = va * 10 + longint'(a[4*i +: 4]);
                vb  = vb * 10 + longint'(b[4*i +: 4]);
                lim = lim * 10;
            end
            t = va + vb + longint'(c);
            e.cout = (t >= lim);
            if (e.cout) t = t - lim;
            for (int i = 0; i < int'(DIGITS); i++) begin
                e.sum[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end else begin
            ca = int'(c);
            for (int i = 0; i < int'(DIGITS); i++) begin
                s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + ca;
                if (s > 9) begin
                    e.sum[4*i +: 4] = 4'(s + 6);
                    ca = 1;
                end else begin
                    e.sum[4*i +: 4] = 4'(s);
                    ca = 0;
                end
            end
            e.cout = (ca != 0);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op(input bit wild);
        logic [W-1:0] v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            v[4*i +: 4] = wild ? 4'($urandom_range(15)) : 4'($urandom_range(9));
        end
        return v;
    endfunction

    // Monitor: compare on done, check output hold otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            last_sum  = '0;
            last_cout = 1'b0;
            last_inv  = 1'b0;
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("sum",       bus.sum,            mon_e.sum);
                check("carry_out", W'(bus.carry_out),  W'(mon_e.cout));
                check("invalid",   W'(bus.invalid),    W'(mon_e.inv));
                check("latency",   W'(cyc),            W'(mon_e.cyc));
                last_sum  = mon_e.sum;
                last_cout = mon_e.cout;
                last_inv  = mon_e.inv;
            end
        end else begin
            check("hold", {bus.sum, bus.carry_out, bus.invalid} >> 2, {last_sum, last_cout, last_inv} >> 2);
            check("hold_flags", W'({bus.carry_out, bus.invalid}), W'({last_cout, last_inv}));
        end
    end

    // Waits for done from the negedge after capture; optionally toggles start/inputs
    task automatic wait_done(input bit noisy, input int exp_busy);
        bit got;
        int nb;
        got = 1'b0;
        nb  = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy) nb++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            bus.start = noisy ? 1'($urandom_range(1)) : 1'b0;
            if (noisy) begin
                bus.in1      = W'($urandom);
                bus.in2      = W'($urandom);
                bus.carry_in = 1'($urandom_range(1));
            end
        end
        bus.start = 1'b0;
        check("done_seen", W'(got), W'(1));
        check("busy_cycles", W'(nb), W'(exp_busy));
    endtask

    // Issues one operation; must be called at a negedge with the DUT idle
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input bit noisy);
        bus.in1      = a;
        bus.in2      = b;
        bus.carry_in = c;
        bus.start    = 1'b1;
        sb.push_back(model(a, b, c, cyc + 6));
        @(negedge clk);
        bus.start = 1'b0;
        if (noisy) begin
            bus.in1 = W'($urandom);
            bus.in2 = W'($urandom);
        end
        wait_done(noisy, 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in1      = '0;
        bus.in2      = '0;
        bus.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy",  W'(bus.busy),      W'(0));
        check("rst_done",  W'(bus.done),      W'(0));
        check("rst_sum",   bus.sum,           W'(0));
        check("rst_cout",  W'(bus.carry_out), W'(0));
        check("rst_inv",   W'(bus.invalid),   W'(0));

        // Directed cases
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        do_op(16'h9999, 16'h9999, 1'b1, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b0, 1'b0);
        do_op(16'h000B, 16'h0003, 1'b0, 1'b0);
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0);

        // Start pulsed while busy is ignored
        bus.in1 = 16'h0005; bus.in2 = 16'h0005; bus.carry_in = 1'b0; bus.start = 1'b1;
        sb.push_back(model(16'h0005, 16'h0005, 1'b0, cyc + 6));
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1; bus.in1 = 16'h1111;
        @(negedge clk); bus.start = 1'b0;
        wait_done(1'b0, 4);
        repeat (8) @(negedge clk);

        // Start held high re-triggers on the idle cycle after done
        bus.in1 = 16'h4567; bus.in2 = 16'h5555; bus.carry_in = 1'b1; bus.start = 1'b1;
        sb.push_back(model(16'h4567, 16'h5555, 1'b1, cyc + 6));
        sb.push_back(model(16'h4567, 16'h5555, 1'b1, cyc + 12));
        repeat (7) @(negedge clk);
        bus.start = 1'b0;
        wait_done(1'b0, 5);

        // Reset mid-operation abandons it
        bus.in1 = 16'h1234; bus.in2 = 16'h1111; bus.start = 1'b1;
        sb.push_back(model(16'h1234, 16'h1111, 1'b0, cyc + 6));
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", W'(bus.busy),      W'(0));
        check("midrst_done", W'(bus.done),      W'(0));
        check("midrst_sum",  bus.sum,           W'(0));
        check("midrst_cout", W'(bus.carry_out), W'(0));
        check("midrst_inv",  W'(bus.invalid),   W'(0));
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_op(16'h0909, 16'h0101, 1'b0, 1'b0);

        // Randomized operations with noisy inputs and random gaps
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            do_op(rnd_op($urandom_range(7) == 0), rnd_op($urandom_range(7) == 0),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        repeat (10) @(negedge clk);
        check("sb_empty", W'(sb.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit BCD adder that sums two DIGITS-wide packed-BCD operands one decimal digit per clock, least-significant digit first.
- Contains its own single-digit BCD add/correct stage and a registered carry chain between digits.
- Sits upstream of result/display logic, and is the sequential wrapper the team's single-digit BCD adder lacks.
- Start/busy/done handshake to the controlling logic.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- in1  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
- in2  input  4*DIGITS  operand B, packed BCD
- carry_in  input  1  decimal carry into digit 0
- busy  output  1  high while an operation is in progress (ADD or DONE)
- done  output  1  one-cycle pulse; sum/carry_out/invalid valid from this cycle
- sum  output  4*DIGITS  packed BCD result
- carry_out  output  1  decimal carry out of the most-significant digit
- invalid  output  1  at least one operand digit was >9 in the completed operation

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carry_out=0, invalid=0.
  - All internal operand, carry and index registers clear.
  - Reset mid-operation abandons the operation; no done pulse is produced afterwards.
- States and transitions:
  - IDLE -> ADD when start=1.
  - ADD -> ADD while idx < DIGITS-1.
  - ADD -> DONE after the cycle that processes idx = DIGITS-1.
  - DONE -> IDLE unconditionally.
- IDLE, on start=1 (capture edge):
  - Latch in1 and in2 into operand registers.
  - carry register <= carry_in; idx <= 0; result shadow <= 0.
  - invalid_pending <= OR over all 2*DIGITS digits of (digit > 9).
- ADD, each cycle:
  - raw = a[idx] + b[idx] + carry, 5-bit.
  - If raw > 9: digit = (raw + 6)[3:0], carry <= 1.
  - Otherwise: digit = raw[3:0], carry <= 0.
  - Write digit into shadow[idx], then increment idx.
  - The rule applies unchanged to non-BCD digits, so results are deterministic but not meaningful. Example: 1011+0011 gives raw 14, digit 0100, carry 1.
- DONE, single cycle:
  - done=1.
  - sum <= shadow, carry_out <= final carry, invalid <= invalid_pending. All three are visible in the same cycle done is high.
- Output hold: sum, carry_out and invalid hold their values until the next DONE or reset. They do not change during a following operation.
- Latency: start sampled at edge 0; done is high in the cycle after edge DIGITS+1 (5 cycles for DIGITS=4). Back-to-back throughput is one operation per DIGITS+2 cycles.
- busy is 1 in ADD and DONE, 0 in IDLE. It rises the cycle after start is accepted.
- Start handling:
  - start is level-sampled in IDLE only. A start held high re-triggers on the IDLE cycle after DONE.
  - start asserted in ADD/DONE is ignored and not queued.
  - Inputs changing after capture have no effect.
- Width rules: all arithmetic is 5-bit per digit. Maximum raw is 9+9+1 = 19 for valid BCD, 15+15+1 = 31 otherwise. idx width is clog2(DIGITS), minimum 1.

Test Plan:
- DIGITS=4, in1=0x1234, in2=0x5678, carry_in=0, start one cycle -> done exactly 5 cycles after the start edge, sum=0x6912, carry_out=0, invalid=0, busy high 5 cycles.
- in1=0x9999, in2=0x0001, carry_in=0 -> carry ripples through all digits: sum=0x0000, carry_out=1.
- in1=0x9999, in2=0x9999, carry_in=1 -> sum=0x9999, carry_out=1; then in1=0x0000, in2=0x0000, carry_in=0 -> sum=0x0000, carry_out=0. Confirms carry state does not leak between operations.
- in1=0x000B, in2=0x0003, carry_in=0 -> sum=0x0014, carry_out=0, invalid=1; next operation with valid digits -> invalid=0.
- Start with in1=0x0005, in2=0x0005, then pulse start with in1=0x1111 two cycles later (while busy) -> single done, sum=0x0010; the second start produces no extra done.
- Start an operation, drive rst_n=0 at cycle 2 for one cycle -> outputs 0 immediately, no done pulse; a new operation 0x0909+0x0101 then completes with sum=0x1010, carry_out=0.
